ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter granting two requesters access to one shared RAM.
// Each access walks IDLE -> SERVE -> ACK; the RAM is driven only during SERVE.
`default_nettype none

module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_sel,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic [DATA_W-1:0]   din_hold_q;
  logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;

  logic                w_serve;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        // Contention goes to whoever did not win last time.
        if (req_a && req_b) begin
          owner_d      = ~last_owner_q;
          last_owner_d = ~last_owner_q;
          state_d      = SERVE;
        end else if (req_a) begin
          owner_d      = 1'b0;
          last_owner_d = 1'b0;
          state_d      = SERVE;
        end else if (req_b) begin
          owner_d      = 1'b1;
          last_owner_d = 1'b1;
          state_d      = SERVE;
        end
      end
      SERVE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign w_serve = (state_q == SERVE);
  assign w_we    = owner_q ? we_b    : we_a;
  assign w_addr  = owner_q ? addr_b  : addr_a;
  assign w_wdata = owner_q ? wdata_b : wdata_a;

  // Address and data track the owner in SERVE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_q <= '0;
      din_hold_q  <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else if (w_serve) begin
      addr_hold_q <= w_addr;
      din_hold_q  <= w_wdata;
      if (!w_we) begin
        if (owner_q) rdata_b_q <= ram_dout;
        else         rdata_a_q <= ram_dout;
      end
    end
  end

  assign ram_addr = w_serve ? w_addr  : addr_hold_q;
  assign ram_din  = w_serve ? w_wdata : din_hold_q;
  assign ram_sel  = w_serve & w_we;
  assign ack_a    = (state_q == ACK) & ~owner_q;
  assign ack_b    = (state_q == ACK) &  owner_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x8 RAM attached.
`default_nettype none

module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata_a, rdata_b;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_sel, busy, owner;

  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_sel(ram_sel),
    .ram_dout(ram_dout), .busy(busy), .owner(owner)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_sel)    mem[ram_addr] <= ram_din;
    else if (bd_we) mem[bd_addr]  <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    step();
    bd_we = 1'b0;
  endtask

  // Cycle 1 is the cycle in which the request is first sampled.
  task automatic serve(input int budget, output int ta, output int tb);
    int n;
    ta = 0; tb = 0; n = 1;
    while ((req_a || req_b) && n <= budget) begin
      if (ack_a) begin if (ta == 0) ta = n; req_a = 1'b0; end
      if (ack_b) begin if (tb == 0) tb = n; req_b = 1'b0; end
      if (req_a || req_b) begin step(); n++; end
    end
    if (req_a || req_b) begin
      chk("serve_timeout", 1, 0);
      req_a = 1'b0; req_b = 1'b0;
    end
    step();
  endtask

  int ta, tb;
  int grants, sel_err, sel_cnt, na;
  logic gseq [8];
  logic rearm_a, rearm_b, serve_c;

  initial begin
    rst = 1'b1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_sel", ram_sel, 0);
    chk("rst_acks", {ack_a, ack_b}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdata", {rdata_a, rdata_b}, 0);
    chk("rst_addr_din", {ram_addr, ram_din}, 0);
    rst = 1'b0;
    step();

    // A writes 0x5A to 0x10, then reads it back
    req_a = 1; we_a = 1; addr_a = 8'h10; wdata_a = 8'h5A;
    serve(20, ta, tb);
    chk("wr_a_lat", ta, 3);
    chk("wr_a_no_ackb", tb, 0);
    chk("wr_a_mem", mem[8'h10], 8'h5A);
    req_a = 1; we_a = 0;
    serve(20, ta, tb);
    chk("rd_a_lat", ta, 3);
    chk("rd_a_data", rdata_a, 8'h5A);
    chk("rd_a_no_ackb", tb, 0);

    // Simultaneous requests right after reset: A first, then B
    poke(8'h20, 8'h33);
    rst = 1; step(); rst = 0; step();
    req_a = 1; we_a = 0; addr_a = 8'h10;
    req_b = 1; we_b = 0; addr_b = 8'h20;
    serve(20, ta, tb);
    chk("both_ta", ta, 3);
    chk("both_tb", tb, 6);
    chk("both_rdb", rdata_b, 8'h33);
    chk("both_rda", rdata_a, 8'h5A);

    // Continuous contention: A writes 0x11 to 0x80, B reads 0x20
    req_a = 1; we_a = 1; addr_a = 8'h80; wdata_a = 8'h11;
    req_b = 1; we_b = 0; addr_b = 8'h20;
    grants = 0; sel_err = 0; sel_cnt = 0; rearm_a = 0; rearm_b = 0;
    for (int n = 0; n < 60; n++) begin
      if (rearm_a) begin req_a = 1; rearm_a = 0; end
      if (rearm_b) begin req_b = 1; rearm_b = 0; end
      serve_c = busy && !ack_a && !ack_b;
      if (ram_sel !== (serve_c && owner == 1'b0)) sel_err++;
      if (ram_sel) sel_cnt++;
      if (serve_c && grants < 8) begin
        gseq[grants] = owner;
        grants++;
        if (grants == 8) begin req_a = 0; req_b = 0; end
      end
      if (ack_a) begin req_a = 0; rearm_a = (grants < 8); end
      if (ack_b) begin req_b = 0; rearm_b = (grants < 8); end
      if (grants == 8 && !busy && !req_a && !req_b) break;
      step();
    end
    chk("rr_grants", grants, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_owner%0d", i), gseq[i], i % 2);
    chk("rr_sel_err", sel_err, 0);
    chk("rr_sel_cnt", sel_cnt, 4);
    chk("rr_mem", mem[8'h80], 8'h11);
    chk("rr_rdb", rdata_b, 8'h33);
    step();

    // Reset during B's write SERVE
    poke(8'h00, 8'h12);
    req_b = 1; we_b = 1; addr_b = 8'h00; wdata_b = 8'hFF;
    step();
    chk("rs_sel_pre", ram_sel, 1);
    #2 rst = 1;
    #1;
    chk("rs_sel", ram_sel, 0);
    chk("rs_busy", busy, 0);
    chk("rs_acks", {ack_a, ack_b}, 0);
    chk("rs_owner", owner, 0);
    chk("rs_rdata", {rdata_a, rdata_b}, 0);
    chk("rs_addr_din", {ram_addr, ram_din}, 0);
    req_b = 0;
    step();
    rst = 0;
    na = 0;
    for (int n = 0; n < 4; n++) begin na += ack_b; step(); end
    chk("rs_no_ackb", na, 0);
    chk("rs_mem", mem[8'h00], 8'h12);

    // A reads 0xFF and drops req during SERVE
    poke(8'hFF, 8'hC3);
    req_a = 1; we_a = 0; addr_a = 8'hFF;
    step();
    req_a = 0;
    na = 0;
    for (int n = 0; n < 6; n++) begin
      if (ack_a) chk("drop_rda", rdata_a, 8'hC3);
      na += ack_a;
      step();
    end
    chk("drop_acks", na, 1);
    chk("drop_idle", busy, 0);

    // B write must not disturb its earlier read data
    req_b = 1; we_b = 0; addr_b = 8'h20;
    serve(20, ta, tb);
    chk("b_rd", rdata_b, 8'h33);
    req_b = 1; we_b = 1; addr_b = 8'h40; wdata_b = 8'h77;
    serve(20, ta, tb);
    chk("b_wr_tb", tb, 3);
    chk("b_wr_rdb", rdata_b, 8'h33);
    chk("b_wr_mem", mem[8'h40], 8'h77);
    chk("b_wr_rda", rdata_a, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
